combat_meter: RTL and testbench
===============================

Name: combat_meter

Overview:
- Per-player health and guard tracker for an N-player fighter core.
- Detects hitstun and blockstun entry edges from each player FSM state and applies configurable damage.
- Drains guard on blocks, applies chip damage on guard-broken blocks, and regenerates guard over frames.
- Raises KO and round-over flags for the round controller.

Parameters:
NUM_PLAYERS, 2, number of tracked players
STATE_W, 4, width of each player state code
S_HITSTUN, 9, state code for hitstun
S_BLOCKSTUN, 10, state code for blockstun
MAX_HP, 3, health reload value
MAX_GUARD, 3, guard reload value
HP_W, 3, width of each health and guard field; must satisfy 2^HP_W > max(MAX_HP, MAX_GUARD)
HIT_DMG, 1, health lost per hitstun entry
CHIP_DMG, 1, health lost per blockstun entry while guard is 0
REGEN_FRAMES, 60, frame ticks without a hit or block event before guard gains 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per game frame
round_start  in  1  one-cycle pulse; reloads meters for a new round
player_state  in  NUM_PLAYERS*STATE_W  packed player FSM states; player i at [i*STATE_W +: STATE_W]
health  out  NUM_PLAYERS*HP_W  packed current health
guard  out  NUM_PLAYERS*HP_W  packed current guard
guard_break  out  NUM_PLAYERS  one-cycle pulse when a player's guard reaches 0
ko  out  NUM_PLAYERS  level; player health is 0
round_over  out  1  level; latched when any ko bit sets

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - health = MAX_HP and guard = MAX_GUARD for every player.
  - prev_state = 0.
  - Regen counters = 0.
  - guard_break, ko and round_over all 0.
- All outputs are registered.
- Per-player edge detect, with prev_state[i] registered every cycle:
  - hit_ev = (state == S_HITSTUN) && (prev != S_HITSTUN).
  - blk_ev = (state == S_BLOCKSTUN) && (prev != S_BLOCKSTUN) && (prev != S_HITSTUN).
  - Each player uses only its own prev_state.
- Latency: an event sampled at edge N updates health, guard and guard_break at the same edge. Outputs are visible 1 cycle after the state input changes.
- Hit: health <= saturating health - HIT_DMG, floor 0. Guard is unchanged.
- Block with guard > 0:
  - guard <= guard - 1.
  - guard_break pulses for 1 cycle if the new guard is 0.
- Block with guard == 0: health <= saturating health - CHIP_DMG, floor 0. No guard_break pulse.
- Regen counter, per player, width clog2(REGEN_FRAMES+1):
  - Clears on any hit_ev or blk_ev.
  - Otherwise increments on frame_tick while guard < MAX_GUARD.
  - On frame_tick with count == REGEN_FRAMES-1: guard += 1 and the counter clears.
  - Held at 0 while guard == MAX_GUARD.
  - An event and a frame_tick in the same cycle: the event wins.
- ko[i] <= (next health[i] == 0).
- round_over:
  - Sets the cycle any ko sets and stays set until round_start or rst.
  - While round_over = 1, hit, block and regen updates are suppressed. prev_state still tracks the input.
- Simultaneous KO: several ko bits may set in the same cycle (draw). round_over sets once.
- round_start (synchronous, highest priority after rst):
  - Reload health and guard.
  - Clear counters, ko, guard_break and round_over.
  - prev_state <= current state, so no spurious edge fires on the next cycle.
  - Events coincident with round_start are dropped.
- Held state: a state held in S_HITSTUN for many cycles counts once. Re-entry requires leaving the state.
- Hitstun to blockstun transition: not a block event.
- Implementation: generate loop over players. No combinational path from inputs to outputs.

Test Plan:
- Hit damage: rst, then drive p0 0→9 and hold 5 cycles → health0 goes 3→2 after 1 cycle and stays 2. p1 is unchanged at 3.
- Guard drain and break: p1 enters 10 three times, returning to 0 between entries → guard1 goes 3,2,1,0. guard_break[1] pulses exactly once, on the third entry. A fourth entry gives health1 3→2.
- Regen timing: with guard0 = 1, send 60 frame_ticks with no events → guard0 = 2 exactly at the 60th tick. A block at tick 59 clears the counter; guard regains only 60 ticks later.
- KO, draw and freeze: both players at health 1 enter 9 in the same cycle → ko = 2'b11, round_over = 1. Further hitstun entries leave health at 0 and no regen occurs.
- Round start and reset: pulse round_start while p0 is held in 9 → health = 3/3, guard = 3/3, round_over = 0, and no damage on the following cycle. Assert rst mid-count → outputs return to reset values immediately, without waiting for a clk edge.
- Transitions and widths: p0 sequence 9→10 → no guard change. Parameter run with NUM_PLAYERS = 4, MAX_HP = 7, HIT_DMG = 3 → health steps 7→4→1→0 (saturating), ko set.

Source files
------------

// File: rtl/combat_meter.sv
// combat_meter: per-player health/guard tracker driven by hitstun/blockstun entry edges,
// with chip damage, guard regeneration, KO detection and a latched round-over freeze.
module combat_meter #(
  parameter int NUM_PLAYERS  = 2,
  parameter int STATE_W      = 4,
  parameter int S_HITSTUN    = 9,
  parameter int S_BLOCKSTUN  = 10,
  parameter int MAX_HP       = 3,
  parameter int MAX_GUARD    = 3,
  parameter int HP_W         = 3,
  parameter int HIT_DMG      = 1,
  parameter int CHIP_DMG     = 1,
  parameter int REGEN_FRAMES = 60
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           round_start,
  input  logic [NUM_PLAYERS*STATE_W-1:0] player_state,
  output logic [NUM_PLAYERS*HP_W-1:0]    health,
  output logic [NUM_PLAYERS*HP_W-1:0]    guard,
  output logic [NUM_PLAYERS-1:0]         guard_break,
  output logic [NUM_PLAYERS-1:0]         ko,
  output logic                           round_over
);
  localparam int CW = $clog2(REGEN_FRAMES + 1);
  logic [NUM_PLAYERS-1:0] ko_nxt;
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_p
    logic [STATE_W-1:0] st, prev;
    logic [HP_W-1:0] hp, gd, hp_n, gd_n;
    logic [CW-1:0] cnt, cnt_n;
    logic gb, gb_n, kq, hit, blk, wrap;
    assign st   = player_state[i*STATE_W +: STATE_W];
    assign hit  = st == STATE_W'(S_HITSTUN) && prev != STATE_W'(S_HITSTUN);
    // leaving hitstun straight into blockstun is a combo continuation, not a block
    assign blk  = st == STATE_W'(S_BLOCKSTUN) && prev != STATE_W'(S_BLOCKSTUN) && prev != STATE_W'(S_HITSTUN);
    assign wrap = cnt == CW'(REGEN_FRAMES - 1);
    always_comb begin
      hp_n  = hp;
      gd_n  = gd;
      cnt_n = cnt;
      gb_n  = 1'b0;
      if (!round_over) begin
        if (hit) begin
          hp_n  = hp > HP_W'(HIT_DMG) ? hp - HP_W'(HIT_DMG) : '0;
          cnt_n = '0;
        end else if (blk) begin
          cnt_n = '0;
          hp_n  = gd == '0 ? (hp > HP_W'(CHIP_DMG) ? hp - HP_W'(CHIP_DMG) : '0) : hp;
          gd_n  = gd == '0 ? gd : gd - HP_W'(1);
          gb_n  = gd == HP_W'(1);
        end else if (gd == HP_W'(MAX_GUARD)) begin
          cnt_n = '0;
        end else if (frame_tick) begin
          cnt_n = wrap ? '0 : cnt + CW'(1);
          gd_n  = wrap ? gd + HP_W'(1) : gd;
        end
      end
    end
    assign ko_nxt[i] = hp_n == '0;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        hp   <= HP_W'(MAX_HP);
        gd   <= HP_W'(MAX_GUARD);
        prev <= '0;
        cnt  <= '0;
        gb   <= 1'b0;
        kq   <= 1'b0;
      end else if (round_start) begin
        hp   <= HP_W'(MAX_HP);
        gd   <= HP_W'(MAX_GUARD);
        prev <= st;
        cnt  <= '0;
        gb   <= 1'b0;
        kq   <= 1'b0;
      end else begin
        hp   <= hp_n;
        gd   <= gd_n;
        prev <= st;
        cnt  <= cnt_n;
        gb   <= gb_n;
        kq   <= ko_nxt[i];
      end
    assign health[i*HP_W +: HP_W] = hp;
    assign guard[i*HP_W +: HP_W]  = gd;
    assign guard_break[i]         = gb;
    assign ko[i]                  = kq;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) round_over <= 1'b0;
    else if (round_start) round_over <= 1'b0;
    else round_over <= round_over | (|ko_nxt);
endmodule

// File: tb/tb_combat_meter.sv
// tb_combat_meter: directed checks of combat_meter with default and 4-player/heavy-hit parameters.
module tb_combat_meter;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, round_start = 1'b0;
  logic [7:0] ps = '0;
  logic [15:0] ps_b = '0;
  logic [5:0] health, guard;
  logic [1:0] gb, ko;
  logic ro;
  logic [11:0] health_b, guard_b;
  logic [3:0] gb_b, ko_b;
  logic ro_b;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  combat_meter dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_start(round_start),
    .player_state(ps), .health(health), .guard(guard), .guard_break(gb),
    .ko(ko), .round_over(ro)
  );

  combat_meter #(.NUM_PLAYERS(4), .MAX_HP(7), .HIT_DMG(3)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_start(round_start),
    .player_state(ps_b), .health(health_b), .guard(guard_b), .guard_break(gb_b),
    .ko(ko_b), .round_over(ro_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_health", health, 6'o33);
    chk("rst_guard", guard, 6'o33);
    chk("rst_gb", gb, 2'b00);
    chk("rst_ko", ko, 2'b00);
    chk("rst_ro", ro, 1'b0);
    chk("rst_health_b", health_b, 12'o7777);
    rst = 1'b0;
    // single hit, held for several cycles, counts once
    ps = {4'd0, 4'd9};
    tick(1);
    chk("hit_hp", health, 6'o32);
    tick(4);
    chk("hit_held", health, 6'o32);
    ps = '0;
    tick(1);
    // guard drain on player 1
    ps = {4'd10, 4'd0}; tick(1);
    chk("blk1_guard", guard, 6'o23);
    chk("blk1_gb", gb, 2'b00);
    ps = '0; tick(1);
    ps = {4'd10, 4'd0}; tick(1);
    chk("blk2_guard", guard, 6'o13);
    chk("blk2_gb", gb, 2'b00);
    ps = '0; tick(1);
    ps = {4'd10, 4'd0}; tick(1);
    chk("blk3_guard", guard, 6'o03);
    chk("blk3_gb", gb, 2'b10);
    ps = '0; tick(1);
    chk("gb_clear", gb, 2'b00);
    ps = {4'd10, 4'd0}; tick(1);
    chk("chip_hp", health, 6'o22);
    chk("chip_gb", gb, 2'b00);
    ps = '0; tick(1);
    // drain p0 guard to 1, then regenerate
    ps = {4'd0, 4'd10}; tick(1);
    ps = '0; tick(1);
    ps = {4'd0, 4'd10}; tick(1);
    ps = '0; tick(1);
    chk("pre_regen_guard", guard, 6'o01);
    frame_tick = 1'b1;
    tick(59);
    chk("regen_59", guard, 6'o01);
    tick(1);
    chk("regen_60", guard, 6'o12);
    // block coinciding with the 59th tick restarts the count
    tick(58);
    ps = {4'd0, 4'd10}; tick(1);
    chk("blk_at_59", guard, 6'o11);
    ps = '0; tick(1);
    chk("no_regen_after_blk", guard, 6'o21);
    tick(58);
    chk("regen_late_59", guard[2:0], 3'd1);
    tick(1);
    chk("regen_late_60", guard, 6'o22);
    frame_tick = 1'b0;
    // double KO
    ps = {4'd9, 4'd9}; tick(1);
    chk("pre_ko_hp", health, 6'o11);
    chk("pre_ko_ko", ko, 2'b00);
    ps = '0; tick(1);
    ps = {4'd9, 4'd9}; tick(1);
    chk("draw_hp", health, 6'o00);
    chk("draw_ko", ko, 2'b11);
    chk("draw_ro", ro, 1'b1);
    ps = '0; tick(1);
    ps = {4'd9, 4'd9}; tick(1);
    chk("frozen_hp", health, 6'o00);
    frame_tick = 1'b1;
    tick(70);
    frame_tick = 1'b0;
    chk("frozen_guard", guard, 6'o22);
    chk("frozen_ro", ro, 1'b1);
    // round start with a coincident and then held hitstun entry
    ps = '0; tick(1);
    ps = {4'd0, 4'd9};
    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    chk("rs_health", health, 6'o33);
    chk("rs_guard", guard, 6'o33);
    chk("rs_ro", ro, 1'b0);
    chk("rs_ko", ko, 2'b00);
    tick(1);
    chk("rs_no_damage", health, 6'o33);
    // hitstun straight into blockstun
    ps = {4'd0, 4'd10}; tick(1);
    chk("h2b_guard", guard, 6'o33);
    chk("h2b_health", health, 6'o33);
    ps = '0; tick(1);
    // asynchronous reset mid-count
    ps = {4'd0, 4'd9}; tick(1);
    ps = '0; tick(1);
    ps = {4'd0, 4'd10}; tick(1);
    ps = '0; tick(1);
    chk("pre_arst", {health, guard}, {6'o32, 6'o32});
    frame_tick = 1'b1;
    tick(10);
    frame_tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_health", health, 6'o33);
    chk("arst_guard", guard, 6'o33);
    chk("arst_ro", ro, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    // 4-player instance with heavy hits on player 2
    ps_b = 16'h0900; tick(1);
    chk("b_hit1", health_b, 12'o7477);
    ps_b = '0; tick(1);
    ps_b = 16'h0900; tick(1);
    chk("b_hit2", health_b, 12'o7177);
    chk("b_ko_pre", ko_b, 4'b0000);
    ps_b = '0; tick(1);
    ps_b = 16'h0900; tick(1);
    chk("b_hit3_sat", health_b, 12'o7077);
    chk("b_ko", ko_b, 4'b0100);
    chk("b_ro", ro_b, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
